serial_subtractor8: RTL and testbench

- Bit-serial WIDTH-bit subtractor (diff = a - b), LSB first, one bit per clock.
- Companion to the combinational adder datapath in the Tiny Tapeout top: it performs the inverse operation in a small area, using a shift-register and borrow-flop datapath.
- Instantiated under the tt_um top. Operands come from ui_in/uio_in. Result drives uo_out. Status bits go on uio_out.

---
 rtl/serial_subtractor8.sv | 118 +++++++++++
 tb/tb_serial_subtractor8.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor8.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b), LSB first, one bit per clock.
// Define SERIAL_SUB_SATURATE_EN to clamp diff to zero when the final borrow is set.
module serial_subtractor8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] sa, sa_d;
  logic [WIDTH-1:0] sb, sb_d;
  logic [WIDTH-1:0] res, res_d;
  logic [WIDTH-1:0] diff_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             bor, bor_d;
  logic             borrow_d;
  logic             busy_d;
  logic             done_d;
  logic             dbit;
  logic             bor_nx;

  assign dbit   = sa[0] ^ sb[0] ^ bor;
  assign bor_nx = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bor);

  always_comb begin
    state_d  = state;
    sa_d     = sa;
    sb_d     = sb;
    res_d    = res;
    cnt_d    = cnt;
    bor_d    = bor;
    diff_d   = diff;
    borrow_d = borrow;
    busy_d   = busy;
    done_d   = done;
    unique case (state)
      S_IDLE: begin
        done_d = 1'b0;
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          bor_d   = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sa_d  = sa >> 1;
        sb_d  = sb >> 1;
        res_d = {dbit, res[WIDTH-1:1]};
        bor_d = bor_nx;
        if (cnt == LAST) begin
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_DONE: begin
`ifdef SERIAL_SUB_SATURATE_EN
        diff_d = bor ? '0 : res;
`else
        diff_d = res;
`endif
        borrow_d = bor;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      cnt    <= '0;
      bor    <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (ena) begin
      state  <= state_d;
      sa     <= sa_d;
      sb     <= sb_d;
      res    <= res_d;
      cnt    <= cnt_d;
      bor    <= bor_d;
      diff   <= diff_d;
      borrow <= borrow_d;
      busy   <= busy_d;
      done   <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_subtractor8.sv
// Directed testbench for serial_subtractor8.
// Expected results are hand-computed constants.
module tb_serial_subtractor8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [7:0] diff;
  logic       borrow;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  serial_subtractor8 #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .start  (start),
    .a      (a),
    .b      (b),
    .diff   (diff),
    .borrow (borrow),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start one op, wait for done, check latency, busy span and result.
  task automatic run_op(
    input logic [7:0] ia,
    input logic [7:0] ib,
    input logic [7:0] ed,
    input logic       eb,
    input string      nm
  );
    int lat;
    int bcnt;
    a = ia;
    b = ib;
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 40) begin
      step();
      lat++;
      if (busy) bcnt++;
    end
    n_vec++;
    if (lat !== 9) begin
      n_err++;
      $display("FAIL %s latency: got %0d want 9", nm, lat);
    end
    n_vec++;
    if (bcnt !== 8) begin
      n_err++;
      $display("FAIL %s busy_cycles: got %0d want 8", nm, bcnt);
    end
    n_vec++;
    if (diff !== ed || borrow !== eb) begin
      n_err++;
      $display("FAIL %s result: got diff=%h borrow=%b want diff=%h borrow=%b",
               nm, diff, borrow, ed, eb);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_vec++;
    if ({diff, borrow, busy, done} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_state: got diff=%h borrow=%b busy=%b done=%b want all 0",
               diff, borrow, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [7:0] sat_fe;
    logic [7:0] sat_01;
`ifdef SERIAL_SUB_SATURATE_EN
    sat_fe = 8'h00;
    sat_01 = 8'h00;
`else
    sat_fe = 8'hFE;
    sat_01 = 8'h01;
`endif
    run_op(8'h05, 8'h03, 8'h02, 1'b0, "5-3");
    step();
    n_vec++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL done_pulse: got done=%b want 0", done);
    end
    run_op(8'h03, 8'h05, sat_fe, 1'b1, "3-5");
    run_op(8'h00, 8'h00, 8'h00, 1'b0, "00-00");
    run_op(8'hFF, 8'hFF, 8'h00, 1'b0, "FF-FF");
    run_op(8'h00, 8'hFF, sat_01, 1'b1, "00-FF");
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, "80-01");
  endtask

  task automatic test_ignored_start();
    int pulses;
    int k;
    a = 8'h10;
    b = 8'h01;
    start = 1'b1;
    step();
    start = 1'b0;
    pulses = 0;
    k = 0;
    while (k < 12) begin
      if (k == 2) begin
        a = 8'hAA;
        b = 8'h55;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
      k++;
      if (done) pulses++;
    end
    n_vec++;
    if (pulses !== 1 || diff !== 8'h0F || borrow !== 1'b0) begin
      n_err++;
      $display("FAIL ignored_start: got pulses=%0d diff=%h borrow=%b want 1 0f 0",
               pulses, diff, borrow);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    a = 8'hAA;
    b = 8'h55;
    start = 1'b1;
    lat = 0;
    step();
    while (!done && lat < 40) begin
      step();
      lat++;
    end
    n_vec++;
    if (!done || diff !== 8'h55) begin
      n_err++;
      $display("FAIL b2b_first: got done=%b diff=%h want 1 55", done, diff);
    end
    step();
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_restart: got done=%b busy=%b want 0 1", done, busy);
    end
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      step();
      lat++;
    end
    n_vec++;
    if (lat !== 9 || diff !== 8'h55) begin
      n_err++;
      $display("FAIL b2b_second: got lat=%0d diff=%h want 9 55", lat, diff);
    end
    step();
  endtask

  task automatic test_mid_reset();
    a = 8'h33;
    b = 8'h11;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({diff, borrow, busy, done} !== 11'd0) begin
      n_err++;
      $display("FAIL mid_reset: got diff=%h borrow=%b busy=%b done=%b want all 0",
               diff, borrow, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_op(8'h20, 8'h10, 8'h10, 1'b0, "after_reset");
  endtask

  task automatic test_clock_enable();
    int lat;
    a = 8'h9C;
    b = 8'h3A;
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      ena = (lat >= 3 && lat < 6) ? 1'b0 : 1'b1;
      step();
      lat++;
    end
    ena = 1'b1;
    n_vec++;
    if (lat !== 12 || diff !== 8'h62 || borrow !== 1'b0) begin
      n_err++;
      $display("FAIL ena_stall: got lat=%0d diff=%h borrow=%b want 12 62 0",
               lat, diff, borrow);
    end
    ena = 1'b0;
    step();
    step();
    n_vec++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL ena_done_hold: got done=%b want 1", done);
    end
    ena = 1'b1;
    step();
    n_vec++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL ena_done_clear: got done=%b want 0", done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignored_start();
    test_back_to_back();
    test_mid_reset();
    test_clock_enable();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
